// File: rtl/audio_pkg.sv
// Shared constants for the codec audio receive path: FSM encoding, sample width,
// channel codes and the sample justification helper.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // A word of 'bits' bits sitting in the LSBs is moved to the MSBs, low bits zero.
  function automatic logic [SAMPLE_W-1:0] left_justify(input logic [SAMPLE_W-1:0] w,
                                                       input int bits);
    return w << (SAMPLE_W - bits);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous codec pin, with a history flop
// and an edge flag (rising-only or any-change) comparing against that history.
module sync_edge_det #(
  parameter int STAGES   = 2,
  parameter bit EDGE_ANY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  input  logic i_hist_en,
  output logic o_level,
  output logic o_edge
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  // Synchroniser chain; the history flop only advances when enabled so that a
  // slow qualifier (e.g. bit-clock rise) defines what counts as a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      if (i_hist_en) begin
        r_hist <= r_sync[STAGES-1];
      end
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_edge  = EDGE_ANY ? (o_level ^ r_hist) : (o_level & ~r_hist);

endmodule

// File: rtl/i2s_adc_pair_rx.sv
// WM8731 ADC I2S receiver: deserialises left/right words and emits one aligned
// sample pair per frame. Define CH_SWAP_EN to route right->filter_in, left->desired_in.
module i2s_adc_pair_rx
  import audio_pkg::*;
#(
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bclk,
  input  logic                adclrc,
  input  logic                adcdat,
  output logic [SAMPLE_W-1:0] filter_in,
  output logic                filter_en,
  output logic [SAMPLE_W-1:0] desired_in,
  output logic                desired_en,
  output logic                frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(WORD_BITS - 1);

  logic w_unused_bclk_lvl;
  logic w_bclk_rise;
  logic w_lrc_lvl;
  logic w_lrc_any;
  logic w_dat_lvl;
  logic w_unused_dat_edge;

  logic                r_rise_d;
  logic                r_edge_d;
  logic                r_lrc_d;
  logic                r_dat_d;
  logic [1:0]          r_state;
  logic                r_chan;
  logic [3:0]          r_bit_cnt;
  logic [SAMPLE_W-1:0] r_shreg;
  logic [SAMPLE_W-1:0] r_left_hold;
  logic                r_left_valid;
  logic [SAMPLE_W-1:0] r_filter_in;
  logic [SAMPLE_W-1:0] r_desired_in;
  logic                r_filter_en;
  logic                r_desired_en;
  logic                r_frame_err;

  logic [SAMPLE_W-1:0] w_shreg_next;
  logic [SAMPLE_W-1:0] w_word;

  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_ANY(1'b0)) u_bclk_sync (
    .clk       (clk),
    .rst       (rst),
    .i_async   (bclk),
    .i_hist_en (1'b1),
    .o_level   (w_unused_bclk_lvl),
    .o_edge    (w_bclk_rise)
  );

  // adclrc history advances only on bit-clock rises, so a change is judged
  // against the frame clock seen at the previous data bit.
  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_ANY(1'b1)) u_lrc_sync (
    .clk       (clk),
    .rst       (rst),
    .i_async   (adclrc),
    .i_hist_en (w_bclk_rise),
    .o_level   (w_lrc_lvl),
    .o_edge    (w_lrc_any)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_ANY(1'b0)) u_dat_sync (
    .clk       (clk),
    .rst       (rst),
    .i_async   (adcdat),
    .i_hist_en (1'b1),
    .o_level   (w_dat_lvl),
    .o_edge    (w_unused_dat_edge)
  );

  assign w_shreg_next = {r_shreg[SAMPLE_W-2:0], r_dat_d};
  assign w_word       = left_justify(w_shreg_next, WORD_BITS);

  // Capture stage: bit-clock rise, frame-clock change, channel and data aligned together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise_d <= 1'b0;
      r_edge_d <= 1'b0;
      r_lrc_d  <= 1'b0;
      r_dat_d  <= 1'b0;
    end else begin
      r_rise_d <= w_bclk_rise;
      r_edge_d <= w_bclk_rise & w_lrc_any;
      r_lrc_d  <= w_lrc_lvl;
      r_dat_d  <= w_dat_lvl;
    end
  end

  // Frame FSM: the rise carrying the frame-clock change is the I2S delay bit
  // and is skipped by passing through DELAY; shifting starts at the next rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_chan       <= CH_LEFT;
      r_bit_cnt    <= 4'd0;
      r_shreg      <= '0;
      r_left_hold  <= '0;
      r_left_valid <= 1'b0;
      r_filter_in  <= '0;
      r_desired_in <= '0;
      r_filter_en  <= 1'b0;
      r_desired_en <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_filter_en  <= 1'b0;
      r_desired_en <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE, HOLD: begin
          if (r_rise_d && r_edge_d) begin
            r_chan  <= r_lrc_d;
            r_state <= DELAY;
          end
        end
        DELAY: begin
          if (r_rise_d && r_edge_d) begin
            r_frame_err  <= 1'b1;
            r_left_valid <= 1'b0;
            r_chan       <= r_lrc_d;
          end else begin
            r_bit_cnt <= 4'd0;
            r_shreg   <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_rise_d) begin
            if (r_edge_d) begin
              r_frame_err  <= 1'b1;
              r_left_valid <= 1'b0;
              r_shreg      <= '0;
              r_chan       <= r_lrc_d;
              r_state      <= DELAY;
            end else begin
              r_shreg   <= w_shreg_next;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == LAST_BIT) begin
                r_state <= HOLD;
                if (r_chan == CH_LEFT) begin
                  r_left_hold  <= w_word;
                  r_left_valid <= 1'b1;
                end else if (r_chan == CH_RIGHT && r_left_valid) begin
`ifdef CH_SWAP_EN
                  r_filter_in  <= w_word;
                  r_desired_in <= r_left_hold;
`else
                  r_filter_in  <= r_left_hold;
                  r_desired_in <= w_word;
`endif
                  r_filter_en  <= 1'b1;
                  r_desired_en <= 1'b1;
                  r_left_valid <= 1'b0;
                end
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign filter_in  = r_filter_in;
  assign filter_en  = r_filter_en;
  assign desired_in = r_desired_in;
  assign desired_en = r_desired_en;
  assign frame_err  = r_frame_err;

endmodule
